// File: rtl/mdio_pkg.sv
// mdio_pkg: shared types and constants for the Clause-22 MDIO responder.
//   mdio_state_e    - responder frame FSM states
//   OP_READ/OP_WRITE - Clause-22 opcode values
//   FRAME_DATA_BITS - data field width of a management frame
package mdio_pkg;

  typedef enum logic [3:0] {
    PRE, ST1, ST2, OP, PHYAD, REGAD, TA, DATA, IDLE_FRAME
  } mdio_state_e;

  localparam logic [1:0] OP_READ         = 2'b10;
  localparam logic [1:0] OP_WRITE        = 2'b01;
  localparam int         FRAME_DATA_BITS = 16;

endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: brings the asynchronous MDC/MDIO pad signals into the clk
// domain and detects MDC rising edges.
//   clk, rst  - system clock, async active-high reset
//   mdc       - raw management clock
//   mdio_i    - raw MDIO pad input
//   mdc_rise  - one-clk pulse per synchronized MDC rising edge
//   mdio_s    - synchronized MDIO, same latency as mdc so bits line up with mdc_rise
module mdio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mdc,
  input  logic mdio_i,
  output logic mdc_rise,
  output logic mdio_s
);

  logic [SYNC_STAGES-1:0] mdc_sr;
  logic [SYNC_STAGES-1:0] mdio_sr;
  logic                   mdc_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_sr   <= '0;
      mdio_sr  <= '1;   // idle MDIO line is pulled high
      mdc_prev <= 1'b0;
    end else begin
      mdc_sr   <= {mdc_sr[SYNC_STAGES-2:0], mdc};
      mdio_sr  <= {mdio_sr[SYNC_STAGES-2:0], mdio_i};
      mdc_prev <= mdc_sr[SYNC_STAGES-1];
    end
  end

  assign mdc_rise = mdc_sr[SYNC_STAGES-1] & ~mdc_prev;
  assign mdio_s   = mdio_sr[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO responder (PHY side). Decodes management
// frames sampled on MDC rising edges and converts them to single-cycle
// register strobes; read data is shifted back out on MDIO.
//   clk, rst          - system clock, async active-high reset
//   mdc, mdio_i       - management clock / pad input from the initiator
//   mdio_o, mdio_oe   - registered pad output value / enable
//   reg_addr          - register address of the latest frame
//   reg_wdata         - write data, valid with reg_wr_en
//   reg_wr_en         - one-clk write strobe
//   reg_rd_en         - one-clk read strobe; reg_rdata sampled 2 clk later
//   reg_rdata         - read data from the local register file
//   frame_err         - one-clk pulse on bad ST or OP 00/11
// Build option: MDIO_PRE_SUPPRESS_EN enables preamble suppression after the
// first error-free frame addressed to this PHY; any frame_err re-arms the
// full preamble requirement.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR      = 5'd0,
  parameter int         PREAMBLE_BITS = 32,
  parameter int         SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rdata,
  output logic        frame_err
);

  localparam int             PW       = $clog2(PREAMBLE_BITS + 1);
  localparam logic [PW-1:0]  PRE_FULL = PW'(PREAMBLE_BITS);
  localparam logic [4:0]     LAST_D   = 5'(FRAME_DATA_BITS - 1);
  localparam logic [4:0]     REL_CNT  = 5'(FRAME_DATA_BITS);
`ifdef MDIO_PRE_SUPPRESS_EN
  localparam bit SUP_EN = 1'b1;
`else
  localparam bit SUP_EN = 1'b0;
`endif

  logic          mdc_rise, mdio_s;
  mdio_state_e   state;
  logic [4:0]    bit_cnt;
  logic [PW-1:0] pre_cnt;
  logic [15:0]   sh;
  logic          op_hi, is_read, phy_match;
  logic          rd_pipe;    // reg_rd_en delayed 1 clk; rdata latched on it
  logic          wr_pend;    // reg_wr_en fires the clk after reg_wdata loads
  logic          sup_armed;
  logic          pre_ok;

  mdio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .mdc      (mdc),
    .mdio_i   (mdio_i),
    .mdc_rise (mdc_rise),
    .mdio_s   (mdio_s)
  );

  assign pre_ok = (pre_cnt == PRE_FULL) || (SUP_EN && sup_armed);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PRE;
      bit_cnt   <= '0;
      pre_cnt   <= '0;
      sh        <= '0;
      op_hi     <= 1'b0;
      is_read   <= 1'b0;
      phy_match <= 1'b0;
      rd_pipe   <= 1'b0;
      wr_pend   <= 1'b0;
      sup_armed <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      reg_wr_en <= wr_pend;
      wr_pend   <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;
      rd_pipe   <= reg_rd_en;
      // 2 clk after reg_rd_en; the TA edge is always >= 8 clk away
      if (rd_pipe) sh <= reg_rdata;

      if (state == ST1) begin
        // ST '0' already consumed; move on without waiting for an edge
        state <= ST2;
      end else if (mdc_rise) begin
        case (state)
          PRE: begin
            if (mdio_s) begin
              if (pre_cnt != PRE_FULL) pre_cnt <= pre_cnt + PW'(1);
            end else begin
              pre_cnt <= '0;
              if (pre_ok) state <= ST1;
            end
          end
          ST2: begin
            if (mdio_s) begin
              state   <= OP;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
              sup_armed <= 1'b0;
              state     <= PRE;
            end
          end
          OP: begin
            if (bit_cnt == 5'd0) begin
              op_hi   <= mdio_s;
              bit_cnt <= 5'd1;
            end else begin
              bit_cnt <= '0;
              if ({op_hi, mdio_s} == OP_READ) begin
                is_read <= 1'b1;
                state   <= PHYAD;
              end else if ({op_hi, mdio_s} == OP_WRITE) begin
                is_read <= 1'b0;
                state   <= PHYAD;
              end else begin
                frame_err <= 1'b1;
                sup_armed <= 1'b0;
                state     <= PRE;
              end
            end
          end
          PHYAD: begin
            sh <= {sh[14:0], mdio_s};
            if (bit_cnt == 5'd4) begin
              phy_match <= ({sh[3:0], mdio_s} == PHY_ADDR);
              bit_cnt   <= '0;
              state     <= REGAD;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          REGAD: begin
            sh <= {sh[14:0], mdio_s};
            if (bit_cnt == 5'd4) begin
              reg_addr <= {sh[3:0], mdio_s};
              bit_cnt  <= '0;
              if (!phy_match) begin
                state <= IDLE_FRAME;
              end else begin
                state <= TA;
                if (is_read) reg_rd_en <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          TA: begin
            if (is_read) begin
              // first TA bit is Z from the initiator; we drive the second as 0
              mdio_oe <= 1'b1;
              mdio_o  <= 1'b0;
              bit_cnt <= '0;
              state   <= DATA;
            end else if (bit_cnt == 5'd1) begin
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              bit_cnt <= 5'd1;
            end
          end
          DATA: begin
            if (is_read) begin
              if (bit_cnt == REL_CNT) begin
                // D0 has been sampled by the initiator: release the pad
                mdio_oe   <= 1'b0;
                mdio_o    <= 1'b1;
                sup_armed <= 1'b1;
                bit_cnt   <= '0;
                state     <= PRE;
              end else begin
                mdio_o  <= sh[15];
                sh      <= {sh[14:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
              end
            end else begin
              sh <= {sh[14:0], mdio_s};
              if (bit_cnt == LAST_D) begin
                reg_wdata <= {sh[14:0], mdio_s};
                wr_pend   <= 1'b1;
                sup_armed <= 1'b1;
                bit_cnt   <= '0;
                state     <= PRE;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          IDLE_FRAME: begin
            // skip TA + DATA of a frame for another PHY
            if (bit_cnt == 5'd17) begin
              bit_cnt <= '0;
              state   <= PRE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: state <= PRE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
module tb_mdio_responder;

  localparam logic [4:0] PHY = 5'd0;
  localparam int H = 5;   // MDC half period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mdc = 1'b0;
  logic        tb_oe = 1'b0;
  logic        tb_val = 1'b1;
  logic        mdio_bus;
  logic        mdio_o, mdio_oe, reg_wr_en, reg_rd_en, frame_err;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata = 16'h0000;

  int vectors = 0;
  int miscompares = 0;

  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oe_cnt = 0;
  logic [4:0]  rd_addr_last = '0;
  logic [20:0] wq[$];

  always #5 clk = ~clk;

  assign mdio_bus = mdio_oe ? mdio_o : (tb_oe ? tb_val : 1'b1);

  mdio_responder #(.PHY_ADDR(PHY), .PREAMBLE_BITS(32), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .mdc       (mdc),
    .mdio_i    (mdio_bus),
    .mdio_o    (mdio_o),
    .mdio_oe   (mdio_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_rdata (reg_rdata),
    .frame_err (frame_err)
  );

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_cnt++;
      wq.push_back({reg_addr, reg_wdata});
    end
    if (reg_rd_en) begin
      rd_cnt++;
      rd_addr_last = reg_addr;
    end
    if (frame_err) err_cnt++;
    if (mdio_oe) oe_cnt++;
  end

  task automatic bit_cyc(input logic drv, input logic v, output logic s);
    tb_oe  = drv;
    tb_val = v;
    repeat (H) @(negedge clk);
    s = mdio_bus;   // initiator samples at the rising edge
    mdc = 1'b1;
    repeat (H) @(negedge clk);
    mdc = 1'b0;
  endtask

  task automatic run_frame(input int npre, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] regad, input logic [15:0] wdata,
                           input int ntail, output logic [17:0] samp);
    logic [13:0] hdr;
    logic [17:0] tail;
    logic s;
    hdr  = {2'b01, op, phy, regad};
    tail = {2'b10, wdata};
    samp = '1;
    for (int i = 0; i < npre; i++) bit_cyc(1'b1, 1'b1, s);
    for (int i = 0; i < 14; i++) bit_cyc(1'b1, hdr[13-i], s);
    for (int i = 0; i < ntail; i++) begin
      if (op == 2'b10) bit_cyc(1'b0, 1'b0, s);
      else             bit_cyc(1'b1, tail[17-i], s);
      samp[17-i] = s;
    end
    tb_oe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (mdio_o !== 1'b1) begin
      miscompares++; $display("FAIL reset_mdio_o got %b exp 1", mdio_o);
    end
    vectors++;
    if (mdio_oe !== 1'b0) begin
      miscompares++; $display("FAIL reset_mdio_oe got %b exp 0", mdio_oe);
    end
    vectors++;
    if ({reg_addr, reg_wdata, reg_wr_en, reg_rd_en, frame_err} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_regs got addr=%h wdata=%h wr=%b rd=%b err=%b exp all 0",
               reg_addr, reg_wdata, reg_wr_en, reg_rd_en, frame_err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int wb, ob, eb;
    logic [17:0] s;
    wb = wr_cnt; ob = oe_cnt; eb = err_cnt;
    run_frame(32, 2'b01, PHY, 5'h04, 16'h01E1, 18, s);
    vectors++;
    if (wr_cnt - wb !== 1) begin
      miscompares++; $display("FAIL write_strobes got %0d exp 1", wr_cnt - wb);
    end
    vectors++;
    if (wq.size() <= wb || wq[wb] !== {5'h04, 16'h01E1}) begin
      miscompares++; $display("FAIL write_addr_data got %h exp %h", (wq.size() > wb) ? wq[wb] : 21'h0, {5'h04, 16'h01E1});
    end
    vectors++;
    if (oe_cnt - ob !== 0) begin
      miscompares++; $display("FAIL write_oe got %0d clk driven exp 0", oe_cnt - ob);
    end
    vectors++;
    if (err_cnt - eb !== 0) begin
      miscompares++; $display("FAIL write_err got %0d exp 0", err_cnt - eb);
    end
  endtask

  task automatic test_read();
    int rb, wb;
    logic [17:0] s;
    rb = rd_cnt; wb = wr_cnt;
    reg_rdata = 16'h0141;
    run_frame(32, 2'b10, PHY, 5'h02, 16'h0000, 18, s);
    vectors++;
    if (rd_cnt - rb !== 1) begin
      miscompares++; $display("FAIL read_strobes got %0d exp 1", rd_cnt - rb);
    end
    vectors++;
    if (rd_addr_last !== 5'h02) begin
      miscompares++; $display("FAIL read_addr got %h exp 02", rd_addr_last);
    end
    vectors++;
    if (s !== {2'b10, 16'h0141}) begin
      miscompares++; $display("FAIL read_bits got %h exp %h", s, {2'b10, 16'h0141});
    end
    vectors++;
    if (mdio_oe !== 1'b0 || wr_cnt - wb !== 0) begin
      miscompares++; $display("FAIL read_release got oe=%b wr=%0d exp oe=0 wr=0", mdio_oe, wr_cnt - wb);
    end
  endtask

  task automatic test_phy_mismatch();
    int rb, ob, wb;
    logic [17:0] s;
    rb = rd_cnt; ob = oe_cnt;
    reg_rdata = 16'hBEEF;
    run_frame(32, 2'b10, PHY ^ 5'd1, 5'h02, 16'h0000, 18, s);
    vectors++;
    if (rd_cnt - rb !== 0) begin
      miscompares++; $display("FAIL mismatch_strobes got %0d exp 0", rd_cnt - rb);
    end
    vectors++;
    if (oe_cnt - ob !== 0 || s !== 18'h3FFFF) begin
      miscompares++; $display("FAIL mismatch_drive got oe_clks=%0d bits=%h exp 0 3ffff", oe_cnt - ob, s);
    end
    wb = wr_cnt;
    run_frame(32, 2'b01, PHY, 5'h05, 16'hA5A5, 18, s);
    vectors++;
    if (wr_cnt - wb !== 1 || wq.size() <= wb || wq[wb] !== {5'h05, 16'hA5A5}) begin
      miscompares++; $display("FAIL mismatch_recover got cnt=%0d exp 1 with 05/a5a5", wr_cnt - wb);
    end
  endtask

  task automatic test_bad_frames();
    int rb, wb, eb;
    logic [17:0] s;
    rb = rd_cnt; wb = wr_cnt; eb = err_cnt;
    run_frame(32, 2'b11, PHY, 5'h03, 16'h0000, 18, s);
    vectors++;
    if (err_cnt - eb !== 1) begin
      miscompares++; $display("FAIL op11_err got %0d exp 1", err_cnt - eb);
    end
    vectors++;
    if (rd_cnt - rb !== 0 || wr_cnt - wb !== 0) begin
      miscompares++; $display("FAIL op11_strobes got rd=%0d wr=%0d exp 0 0", rd_cnt - rb, wr_cnt - wb);
    end
    wb = wr_cnt; eb = err_cnt;
    run_frame(31, 2'b01, PHY, 5'h04, 16'h0055, 18, s);
    vectors++;
    if (wr_cnt - wb !== 0 || err_cnt - eb !== 0) begin
      miscompares++; $display("FAIL short_preamble got wr=%0d err=%0d exp 0 0", wr_cnt - wb, err_cnt - eb);
    end
  endtask

  task automatic test_partial_frame();
    int wb;
    logic [17:0] s;
    do_reset();
    wb = wr_cnt;
    run_frame(32, 2'b01, PHY, 5'h07, 16'h0000, 0, s);
    repeat (20) @(negedge clk);
    // FSM is parked in TA: the new frame's preamble ones fill TA+DATA
    run_frame(32, 2'b01, PHY, 5'h09, 16'h1234, 18, s);
    vectors++;
`ifdef MDIO_PRE_SUPPRESS_EN
    if (wr_cnt - wb !== 2) begin
      miscompares++; $display("FAIL partial_strobes got %0d exp 2", wr_cnt - wb);
    end
`else
    if (wr_cnt - wb !== 1) begin
      miscompares++; $display("FAIL partial_strobes got %0d exp 1", wr_cnt - wb);
    end
`endif
    vectors++;
    if (wq.size() <= wb || wq[wb] !== {5'h07, 16'hFFFF}) begin
      miscompares++; $display("FAIL partial_data got %h exp %h", (wq.size() > wb) ? wq[wb] : 21'h0, {5'h07, 16'hFFFF});
    end
  endtask

  task automatic test_reset_midread();
    int rb;
    logic [17:0] s;
    rb = rd_cnt;
    reg_rdata = 16'h5A3C;
    run_frame(32, 2'b10, PHY, 5'h03, 16'h0000, 7, s);
    vectors++;
    if (mdio_oe !== 1'b1 || rd_cnt - rb !== 1) begin
      miscompares++; $display("FAIL midread_driving got oe=%b rd=%0d exp 1 1", mdio_oe, rd_cnt - rb);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (mdio_oe !== 1'b0 || mdio_o !== 1'b1) begin
      miscompares++; $display("FAIL midread_async got oe=%b o=%b exp 0 1", mdio_oe, mdio_o);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(32, 2'b10, PHY, 5'h03, 16'h0000, 18, s);
    vectors++;
    if (s !== {2'b10, 16'h5A3C}) begin
      miscompares++; $display("FAIL midread_recover got %h exp %h", s, {2'b10, 16'h5A3C});
    end
  endtask

  task automatic test_pre_suppress();
    int rb, ob;
    logic [17:0] s;
    do_reset();
    run_frame(32, 2'b01, PHY, 5'h01, 16'h0040, 18, s);
    rb = rd_cnt; ob = oe_cnt;
    reg_rdata = 16'h7949;
    run_frame(0, 2'b10, PHY, 5'h01, 16'h0000, 18, s);
    vectors++;
`ifdef MDIO_PRE_SUPPRESS_EN
    if (rd_cnt - rb !== 1 || s !== {2'b10, 16'h7949}) begin
      miscompares++; $display("FAIL suppress_read got rd=%0d bits=%h exp 1 %h", rd_cnt - rb, s, {2'b10, 16'h7949});
    end
`else
    if (rd_cnt - rb !== 0 || oe_cnt - ob !== 0) begin
      miscompares++; $display("FAIL suppress_read got rd=%0d oe_clks=%0d exp 0 0", rd_cnt - rb, oe_cnt - ob);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_phy_mismatch();
    test_bad_frames();
    test_partial_frame();
    test_reset_midread();
    test_pre_suppress();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
